stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/pipes_pkg.sv | 33 +++
 rtl/stage_sequencer.sv | 129 ++++++++++++
 tb/tb_stage_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipes_pkg.sv
// Shared pipeline types: sequencer states, stage enables,
// supported opcodes and writeback-source encodings.
package pipes_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK
  } state_t;

  typedef struct packed {
    logic fetch_enable;
    logic decode_enable;
    logic execute_enable;
    logic memory_enable;
    logic writeback_enable;
    logic m_or_e;
  } state_enable_t;

  localparam logic [5:0] F6_R_TYPE = 6'b000000;
  localparam logic [5:0] F6_J      = 6'b000010;
  localparam logic [5:0] F6_BEQ    = 6'b000100;
  localparam logic [5:0] F6_ADDI   = 6'b001000;
  localparam logic [5:0] F6_LW     = 6'b100011;
  localparam logic [5:0] F6_SW     = 6'b101011;

  localparam logic E = 1'b0;
  localparam logic M = 1'b1;

endpackage

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction
// through fetch/decode/execute/memory/writeback and retires it.
module stage_sequencer
  import pipes_pkg::*;
#(
  parameter logic [31:0] COUNT_INIT = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          halt,
  input  logic          i_data_ok,
  input  logic [31:0]   instr,
  input  logic          d_data_ok,
  output state_enable_t en,
  output logic          ireq_valid,
  output logic          dreq_valid,
  output logic          dreq_write,
  output logic          retire,
  output logic          illegal,
  output logic [31:0]   instr_count
);

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic        moe_q, moe_d;
  logic [31:0] count_q;

  logic is_mem, is_br, is_alu, is_sw;

  assign is_sw  = (op_q == F6_SW);
  assign is_mem = (op_q == F6_LW) || is_sw;
  assign is_br  = (op_q == F6_BEQ) || (op_q == F6_J);
  assign is_alu = (op_q == F6_R_TYPE) || (op_q == F6_ADDI);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    moe_d   = moe_q;
    unique case (state_q)
      S_IDLE:
        if (!halt) state_d = S_FETCH;
      S_FETCH:
        if (i_data_ok) state_d = S_DECODE;
      S_DECODE: begin
        op_d    = instr[31:26];
        state_d = (instr == '0) ? S_IDLE : S_EXECUTE;
      end
      S_EXECUTE: begin
        unique case (1'b1)
          is_mem: state_d = S_MEMORY;
          is_alu: begin
            state_d = S_WRITEBACK;
            moe_d   = E;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_MEMORY:
        if (d_data_ok) begin
          if (is_sw) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WRITEBACK;
            moe_d   = M;
          end
        end
      S_WRITEBACK:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the current state; the ok inputs
  // only qualify the enable of the stage that is waiting on them.
  always_comb begin
    en         = '0;
    en.m_or_e  = moe_q;
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
    dreq_write = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_FETCH: begin
        ireq_valid      = 1'b1;
        en.fetch_enable = i_data_ok;
      end
      S_DECODE: begin
        en.decode_enable = 1'b1;
        retire           = (instr == '0);
      end
      S_EXECUTE: begin
        en.execute_enable = 1'b1;
        retire            = !is_mem && !is_alu;
        illegal           = !is_mem && !is_alu && !is_br;
      end
      S_MEMORY: begin
        dreq_valid       = 1'b1;
        dreq_write       = is_sw;
        en.memory_enable = d_data_ok;
        retire           = d_data_ok && is_sw;
      end
      S_WRITEBACK: begin
        en.writeback_enable = 1'b1;
        retire              = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      moe_q   <= E;
      count_q <= COUNT_INIT;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      moe_q   <= moe_d;
      if (retire) count_q <= count_q + 32'd1;
    end
  end

  assign instr_count = count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: table of instructions with memory
// latencies, retire scoreboard, plus reset/halt sequences.
module tb_stage_sequencer;
  import pipes_pkg::*;

  logic          clk = 1'b0;
  logic          reset, halt, i_data_ok, d_data_ok;
  logic [31:0]   instr;
  state_enable_t en, en_w;
  logic ireq_valid, dreq_valid, dreq_write, retire, illegal;
  logic ireq_w, dreq_w, dwr_w, ret_w, ill_w;
  logic [31:0] instr_count, instr_count_w;

  always #5 clk = ~clk;

  stage_sequencer dut (
    .clk(clk), .reset(reset), .halt(halt),
    .i_data_ok(i_data_ok), .instr(instr),
    .d_data_ok(d_data_ok), .en(en),
    .ireq_valid(ireq_valid), .dreq_valid(dreq_valid),
    .dreq_write(dreq_write), .retire(retire),
    .illegal(illegal), .instr_count(instr_count)
  );

  // Second copy starts its counter at all-ones to reach the wrap.
  stage_sequencer #(.COUNT_INIT(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .reset(reset), .halt(halt),
    .i_data_ok(i_data_ok), .instr(instr),
    .d_data_ok(d_data_ok), .en(en_w),
    .ireq_valid(ireq_w), .dreq_valid(dreq_w),
    .dreq_write(dwr_w), .retire(ret_w),
    .illegal(ill_w), .instr_count(instr_count_w)
  );

  typedef struct {
    logic [31:0] instr;
    int iw, dw;
    bit spur;
    int f, d, e, m, w, ret, dreq;
    bit wr, moe, ill;
  } vec_t;

  typedef struct {
    bit ill;
    logic [31:0] cnt;
  } sb_t;

  sb_t sbq[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] model_cnt;
  vec_t tbl[10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] i, input int iw, dw, input bit sp,
    input int f, d, e, m, w, ret, dq,
    input bit wr, moe, ill);
    vec_t v;
    v.instr = i; v.iw = iw; v.dw = dw; v.spur = sp;
    v.f = f; v.d = d; v.e = e; v.m = m; v.w = w;
    v.ret = ret; v.dreq = dq;
    v.wr = wr; v.moe = moe; v.ill = ill;
    return v;
  endfunction

  task automatic run_instr(input vec_t v, input string nm);
    int fw = 0, dwc = 0, n;
    int f = 0, d = 0, e = 0, m = 0, w = 0, ret = 0, dq = 0;
    bit wr = 0, moe = 0, got = 0;
    sb_t s;
    sb_t exp_s;
    model_cnt = model_cnt + 32'd1;
    exp_s.ill = v.ill;
    exp_s.cnt = model_cnt;
    sbq.push_back(exp_s);
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      halt  = 1'b0;
      instr = v.instr;
      i_data_ok = ireq_valid ? (fw == v.iw) : v.spur;
      d_data_ok = dreq_valid ? (dwc == v.dw) : v.spur;
      if (ireq_valid) fw++;
      if (dreq_valid) dwc++;
      #1;
      n = $countones({en.fetch_enable, en.decode_enable,
                      en.execute_enable, en.memory_enable,
                      en.writeback_enable});
      chk({nm, " one_enable"}, 32'(n <= 1), 32'd1);
      chk({nm, " illegal_only_at_retire"},
          32'(illegal && !retire), 32'd0);
      if (en.fetch_enable && f == 0) f = c;
      if (en.decode_enable && d == 0) d = c;
      if (en.execute_enable && e == 0) e = c;
      if (en.memory_enable && m == 0) m = c;
      if (en.writeback_enable && w == 0) w = c;
      if (dreq_valid) dq++;
      if (dreq_write) wr = 1'b1;
      if (retire) begin
        got = 1'b1;
        ret = c;
        moe = en.m_or_e;
        chk({nm, " sb_depth"}, 32'(sbq.size()), 32'd1);
        if (sbq.size() > 0) begin
          s = sbq.pop_front();
          chk({nm, " illegal"}, 32'(illegal), 32'(s.ill));
        end
      end
    end
    chk({nm, " retired"}, 32'(got), 32'd1);
    if (got) begin
      @(posedge clk);
      #1;
      chk({nm, " instr_count"}, instr_count, s.cnt);
      chk({nm, " instr_count_wrap"}, instr_count_w,
          s.cnt - 32'd1);
    end else begin
      sbq.delete();
    end
    chk({nm, " fetch_cyc"}, 32'(f), 32'(v.f));
    chk({nm, " decode_cyc"}, 32'(d), 32'(v.d));
    chk({nm, " execute_cyc"}, 32'(e), 32'(v.e));
    chk({nm, " memory_cyc"}, 32'(m), 32'(v.m));
    chk({nm, " writeback_cyc"}, 32'(w), 32'(v.w));
    chk({nm, " retire_cyc"}, 32'(ret), 32'(v.ret));
    chk({nm, " dreq_cycles"}, 32'(dq), 32'(v.dreq));
    chk({nm, " dreq_write"}, 32'(wr), 32'(v.wr));
    chk({nm, " m_or_e"}, 32'(moe), 32'(v.moe));
  endtask

  task automatic check_halted(input string nm);
    @(negedge clk);
    #1;
    chk({nm, " ireq_valid"}, 32'(ireq_valid), 32'd0);
    chk({nm, " en"}, 32'(en), 32'd0);
    chk({nm, " retire"}, 32'(retire), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    bit seen;
    string nm;
    //      instr         iw dw sp  f d e m w ret dq wr moe ill
    tbl[0] = mk(32'h0022_1820, 0, 0, 0, 2, 3, 4, 0, 5, 5, 0, 0, 0, 0);
    tbl[1] = mk(32'h8C22_0004, 0, 3, 0, 2, 3, 4, 8, 9, 9, 4, 0, 1, 0);
    tbl[2] = mk(32'hAC22_0004, 0, 0, 0, 2, 3, 4, 5, 0, 5, 1, 1, 1, 0);
    tbl[3] = mk(32'h1022_0003, 0, 0, 0, 2, 3, 4, 0, 0, 4, 0, 0, 1, 0);
    tbl[4] = mk(32'h0000_0000, 0, 0, 0, 2, 3, 0, 0, 0, 3, 0, 0, 1, 0);
    tbl[5] = mk(32'hFC00_0000, 0, 0, 0, 2, 3, 4, 0, 0, 4, 0, 0, 1, 1);
    tbl[6] = mk(32'h2022_0005, 2, 0, 1, 4, 5, 6, 0, 7, 7, 0, 0, 0, 0);
    tbl[7] = mk(32'h0800_0010, 1, 0, 0, 3, 4, 5, 0, 0, 5, 0, 0, 0, 0);
    tbl[8] = mk(32'h8C22_0004, 1, 0, 1, 3, 4, 5, 6, 7, 7, 1, 0, 1, 0);
    tbl[9] = mk(32'hAC22_0004, 0, 2, 1, 2, 3, 4, 7, 0, 7, 3, 1, 1, 0);

    reset = 1'b0; halt = 1'b1;
    i_data_ok = 1'b0; d_data_ok = 1'b0; instr = '0;
    model_cnt = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset en", 32'(en), 32'd0);
    chk("reset req", 32'({ireq_valid, dreq_valid, dreq_write}), 32'd0);
    chk("reset pulses", 32'({retire, illegal}), 32'd0);
    chk("reset instr_count", instr_count, 32'd0);
    chk("reset instr_count_wrap", instr_count_w, 32'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) check_halted("halt_after_reset");

    for (int i = 0; i < 10; i++) begin
      nm = $sformatf("vec%0d", i);
      run_instr(tbl[i], nm);
    end

    // Abort an LW that is stuck waiting on data memory.
    nd = 0;
    seen = 1'b0;
    instr = 32'h8C22_0004;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      halt = 1'b0;
      i_data_ok = ireq_valid;
      d_data_ok = 1'b0;
      #1;
      if (dreq_valid) nd++;
      seen = (nd >= 2);
    end
    chk("reached_memory_wait", 32'(seen), 32'd1);
    #1;
    reset = 1'b0;
    halt  = 1'b1;
    #1;
    chk("abort en", 32'(en), 32'd0);
    chk("abort req", 32'({ireq_valid, dreq_valid, dreq_write}), 32'd0);
    chk("abort pulses", 32'({retire, illegal}), 32'd0);
    chk("abort instr_count", instr_count, 32'd0);
    chk("abort instr_count_wrap", instr_count_w, 32'hFFFF_FFFF);
    model_cnt = '0;
    sbq.delete();
    @(negedge clk);
    reset = 1'b1;
    i_data_ok = 1'b1;
    d_data_ok = 1'b1;
    for (int k = 0; k < 4; k++) check_halted("halt_held");
    chk("halt instr_count", instr_count, 32'd0);

    run_instr(mk(32'h0000_0000, 0, 0, 0, 2, 3, 0, 0, 0, 3, 0, 0, 0, 0),
              "nop_after_abort");
    run_instr(tbl[0], "add_after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
